// File: rtl/rca_config_pkg.sv
// Shared definitions for the RCA configuration loader: opcodes, packet field layout
// and default sizing of the RCA configuration register file.
package rca_config_pkg;

    localparam int unsigned DEF_NUM_RCAS           = 4;
    localparam int unsigned DEF_NUM_READ_PORTS     = 2;
    localparam int unsigned DEF_NUM_WRITE_PORTS    = 2;
    localparam int unsigned DEF_GRID_NUM_ROWS      = 4;
    localparam int unsigned DEF_NUM_GRID_MUXES     = 32;
    localparam int unsigned DEF_GRID_MUX_INPUTS    = 8;
    localparam int unsigned DEF_IO_UNIT_MUX_INPUTS = 8;

    localparam int unsigned CFG_WORD_W = 32;
    localparam int unsigned CFG_CNT_W  = 16;

    typedef enum logic [3:0] {
        OpSrcFb     = 4'd0,
        OpDestFb    = 4'd1,
        OpDestNfb   = 4'd2,
        OpGridMux   = 4'd3,
        OpIoMux     = 4'd4,
        OpResultFb  = 4'd5,
        OpResultNfb = 4'd6,
        OpIoInpMap  = 4'd7
    } rca_cfg_op_t;

    typedef struct packed {
        logic [3:0]           op;
        logic [3:0]           id;
        logic [7:0]           rsvd;
        logic [CFG_CNT_W-1:0] count;
    } rca_cfg_hdr_t;

    typedef struct packed {
        logic [15:0] index;
        logic [15:0] value;
    } rca_cfg_pl_t;

    // Opcodes 8-15 are reserved.
    function automatic logic op_is_illegal(input logic [3:0] op);
        return op[3];
    endfunction

endpackage

// File: rtl/rca_config_loader.sv
// Turns a stream of 32-bit configuration packets (header + N payload words) into
// single-cycle registered write strobes on the RCA configuration register file.
module rca_config_loader
    import rca_config_pkg::*;
#(
    parameter int unsigned NUM_RCAS           = DEF_NUM_RCAS,
    parameter int unsigned NUM_READ_PORTS     = DEF_NUM_READ_PORTS,
    parameter int unsigned NUM_WRITE_PORTS    = DEF_NUM_WRITE_PORTS,
    parameter int unsigned GRID_NUM_ROWS      = DEF_GRID_NUM_ROWS,
    parameter int unsigned NUM_GRID_MUXES     = DEF_NUM_GRID_MUXES,
    parameter int unsigned GRID_MUX_INPUTS    = DEF_GRID_MUX_INPUTS,
    parameter int unsigned IO_UNIT_MUX_INPUTS = DEF_IO_UNIT_MUX_INPUTS
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [CFG_WORD_W-1:0]                 cfg_data,
    input  logic                                  cfg_valid,
    output logic                                  cfg_ready,
    output logic [$clog2(NUM_RCAS)-1:0]           rca_sel_issue,
    output logic                                  cpu_fb_reg_addr_wr_en,
    output logic                                  cpu_nfb_reg_addr_wr_en,
    output logic [$clog2(NUM_READ_PORTS)-1:0]     cpu_port_sel,
    output logic                                  cpu_src_dest_port,
    output logic [4:0]                            cpu_reg_addr,
    output logic                                  grid_mux_wr_en,
    output logic [$clog2(NUM_GRID_MUXES)-1:0]     grid_mux_wr_addr,
    output logic [$clog2(GRID_MUX_INPUTS)-1:0]    new_grid_mux_sel,
    output logic                                  io_mux_wr_en,
    output logic [$clog2(GRID_NUM_ROWS)-1:0]      io_mux_addr,
    output logic [$clog2(IO_UNIT_MUX_INPUTS)-1:0] new_io_mux_sel,
    output logic                                  rca_fb_result_mux_wr_en,
    output logic                                  rca_nfb_result_mux_wr_en,
    output logic [$clog2(NUM_WRITE_PORTS)-1:0]    rca_result_mux_addr,
    output logic [$clog2(GRID_NUM_ROWS)-1:0]      new_rca_result_mux_sel,
    output logic                                  rca_io_inp_map_wr_en,
    output logic [GRID_NUM_ROWS-1:0]              new_rca_io_inp_map,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  err
);

    localparam int unsigned RCA_W      = $clog2(NUM_RCAS);
    localparam int unsigned PORT_W     = $clog2(NUM_READ_PORTS);
    localparam int unsigned GRID_A_W   = $clog2(NUM_GRID_MUXES);
    localparam int unsigned GRID_S_W   = $clog2(GRID_MUX_INPUTS);
    localparam int unsigned IO_A_W     = $clog2(GRID_NUM_ROWS);
    localparam int unsigned IO_S_W     = $clog2(IO_UNIT_MUX_INPUTS);
    localparam int unsigned RES_A_W    = $clog2(NUM_WRITE_PORTS);
    localparam int unsigned RES_S_W    = $clog2(GRID_NUM_ROWS);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]           state_q;
    logic [CFG_CNT_W-1:0] count_q;
    logic [3:0]           op_q;
    logic                 err_latch_q;

    rca_cfg_hdr_t hdr;
    rca_cfg_pl_t  pl;
    logic         accept;
    logic         hdr_bad;
    logic         last_word;
    logic [31:0]  idx_ext;
    logic         idx_ok;
    logic         unused_bits;

    assign hdr         = rca_cfg_hdr_t'(cfg_data);
    assign pl          = rca_cfg_pl_t'(cfg_data);
    assign unused_bits = ^{hdr.rsvd, pl.value};
    assign idx_ext     = {16'd0, pl.index};
    assign hdr_bad     = op_is_illegal(hdr.op) || ({28'd0, hdr.id} >= NUM_RCAS);
    assign last_word   = (count_q == 16'd1);

    // The done cycle itself is also not ready, so a new header lands the cycle after done.
    assign cfg_ready = !rst && (state_q != ST_DONE) && !done;
    assign accept    = cfg_valid && cfg_ready;

    always_comb begin
        idx_ok = 1'b0;
        case (op_q)
            OpSrcFb:                   idx_ok = idx_ext < NUM_READ_PORTS;
            OpDestFb, OpDestNfb:       idx_ok = idx_ext < NUM_WRITE_PORTS;
            OpGridMux:                 idx_ok = idx_ext < NUM_GRID_MUXES;
            OpIoMux:                   idx_ok = idx_ext < GRID_NUM_ROWS;
            OpResultFb, OpResultNfb:   idx_ok = idx_ext < NUM_WRITE_PORTS;
            OpIoInpMap:                idx_ok = 1'b1;
            default:                   idx_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q                  <= ST_IDLE;
            count_q                  <= '0;
            op_q                     <= '0;
            err_latch_q              <= 1'b0;
            rca_sel_issue            <= '0;
            cpu_fb_reg_addr_wr_en    <= 1'b0;
            cpu_nfb_reg_addr_wr_en   <= 1'b0;
            cpu_port_sel             <= '0;
            cpu_src_dest_port        <= 1'b0;
            cpu_reg_addr             <= '0;
            grid_mux_wr_en           <= 1'b0;
            grid_mux_wr_addr         <= '0;
            new_grid_mux_sel         <= '0;
            io_mux_wr_en             <= 1'b0;
            io_mux_addr              <= '0;
            new_io_mux_sel           <= '0;
            rca_fb_result_mux_wr_en  <= 1'b0;
            rca_nfb_result_mux_wr_en <= 1'b0;
            rca_result_mux_addr      <= '0;
            new_rca_result_mux_sel   <= '0;
            rca_io_inp_map_wr_en     <= 1'b0;
            new_rca_io_inp_map       <= '0;
            busy                     <= 1'b0;
            done                     <= 1'b0;
            err                      <= 1'b0;
        end else begin
            cpu_fb_reg_addr_wr_en    <= 1'b0;
            cpu_nfb_reg_addr_wr_en   <= 1'b0;
            grid_mux_wr_en           <= 1'b0;
            io_mux_wr_en             <= 1'b0;
            rca_fb_result_mux_wr_en  <= 1'b0;
            rca_nfb_result_mux_wr_en <= 1'b0;
            rca_io_inp_map_wr_en     <= 1'b0;
            done                     <= 1'b0;
            err                      <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        rca_sel_issue <= hdr.id[RCA_W-1:0];
                        count_q       <= hdr.count;
                        op_q          <= hdr.op;
                        busy          <= 1'b1;
                        if (hdr.count == '0) begin
                            state_q <= ST_DONE;
                        end else if (hdr_bad) begin
                            state_q     <= ST_DRAIN;
                            err_latch_q <= 1'b1;
                        end else begin
                            state_q <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    if (accept) begin
                        count_q <= count_q - 16'd1;
                        if (last_word) begin
                            state_q <= ST_DONE;
                        end
                        if (!idx_ok) begin
                            err_latch_q <= 1'b1;
                        end else begin
                            case (op_q)
                                OpSrcFb, OpDestFb: begin
                                    cpu_fb_reg_addr_wr_en <= 1'b1;
                                    cpu_src_dest_port     <= (op_q == OpDestFb);
                                    cpu_port_sel          <= pl.index[PORT_W-1:0];
                                    cpu_reg_addr          <= pl.value[4:0];
                                end
                                OpDestNfb: begin
                                    cpu_nfb_reg_addr_wr_en <= 1'b1;
                                    cpu_src_dest_port      <= 1'b1;
                                    cpu_port_sel           <= pl.index[PORT_W-1:0];
                                    cpu_reg_addr           <= pl.value[4:0];
                                end
                                OpGridMux: begin
                                    grid_mux_wr_en   <= 1'b1;
                                    grid_mux_wr_addr <= pl.index[GRID_A_W-1:0];
                                    new_grid_mux_sel <= pl.value[GRID_S_W-1:0];
                                end
                                OpIoMux: begin
                                    io_mux_wr_en   <= 1'b1;
                                    io_mux_addr    <= pl.index[IO_A_W-1:0];
                                    new_io_mux_sel <= pl.value[IO_S_W-1:0];
                                end
                                OpResultFb, OpResultNfb: begin
                                    rca_fb_result_mux_wr_en  <= (op_q == OpResultFb);
                                    rca_nfb_result_mux_wr_en <= (op_q == OpResultNfb);
                                    rca_result_mux_addr      <= pl.index[RES_A_W-1:0];
                                    new_rca_result_mux_sel   <= pl.value[RES_S_W-1:0];
                                end
                                OpIoInpMap: begin
                                    rca_io_inp_map_wr_en <= 1'b1;
                                    new_rca_io_inp_map   <= pl.value[GRID_NUM_ROWS-1:0];
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                ST_DRAIN: begin
                    if (accept) begin
                        count_q <= count_q - 16'd1;
                        if (last_word) begin
                            state_q <= ST_DONE;
                        end
                    end
                end
                default: begin
                    // DONE: the last write is on the outputs now; report one cycle later.
                    done        <= 1'b1;
                    err         <= err_latch_q;
                    err_latch_q <= 1'b0;
                    busy        <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rca_config_loader.sv
// Randomised bench for rca_config_loader with a packet-level reference model and
// directed packets whose results are also pinned by literal expectations.
module tb_rca_config_loader;

    logic        clk;
    logic        rst;
    logic [31:0] cfg_data;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [1:0]  rca_sel_issue;
    logic        cpu_fb_reg_addr_wr_en;
    logic        cpu_nfb_reg_addr_wr_en;
    logic [0:0]  cpu_port_sel;
    logic        cpu_src_dest_port;
    logic [4:0]  cpu_reg_addr;
    logic        grid_mux_wr_en;
    logic [4:0]  grid_mux_wr_addr;
    logic [2:0]  new_grid_mux_sel;
    logic        io_mux_wr_en;
    logic [1:0]  io_mux_addr;
    logic [2:0]  new_io_mux_sel;
    logic        rca_fb_result_mux_wr_en;
    logic        rca_nfb_result_mux_wr_en;
    logic [0:0]  rca_result_mux_addr;
    logic [1:0]  new_rca_result_mux_sel;
    logic        rca_io_inp_map_wr_en;
    logic [3:0]  new_rca_io_inp_map;
    logic        busy;
    logic        done;
    logic        err;

    rca_config_loader dut (
        .clk                      (clk),
        .rst                      (rst),
        .cfg_data                 (cfg_data),
        .cfg_valid                (cfg_valid),
        .cfg_ready                (cfg_ready),
        .rca_sel_issue            (rca_sel_issue),
        .cpu_fb_reg_addr_wr_en    (cpu_fb_reg_addr_wr_en),
        .cpu_nfb_reg_addr_wr_en   (cpu_nfb_reg_addr_wr_en),
        .cpu_port_sel             (cpu_port_sel),
        .cpu_src_dest_port        (cpu_src_dest_port),
        .cpu_reg_addr             (cpu_reg_addr),
        .grid_mux_wr_en           (grid_mux_wr_en),
        .grid_mux_wr_addr         (grid_mux_wr_addr),
        .new_grid_mux_sel         (new_grid_mux_sel),
        .io_mux_wr_en             (io_mux_wr_en),
        .io_mux_addr              (io_mux_addr),
        .new_io_mux_sel           (new_io_mux_sel),
        .rca_fb_result_mux_wr_en  (rca_fb_result_mux_wr_en),
        .rca_nfb_result_mux_wr_en (rca_nfb_result_mux_wr_en),
        .rca_result_mux_addr      (rca_result_mux_addr),
        .new_rca_result_mux_sel   (new_rca_result_mux_sel),
        .rca_io_inp_map_wr_en     (rca_io_inp_map_wr_en),
        .new_rca_io_inp_map       (new_rca_io_inp_map),
        .busy                     (busy),
        .done                     (done),
        .err                      (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;
    int max_gap = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (packet level) ----------------
    bit          m_open, m_drop, m_err_acc, m_err_pend;
    int          m_rem, m_op, m_cool, m_done_cnt;
    bit          m_acc;
    logic [31:0] m_w;
    // expected outputs for the current cycle
    bit          e_wr, e_done, e_err, e_busy;
    int          e_op, e_rca, e_idx, e_val;

    function automatic int idx_limit(input int op);
        case (op)
            0, 1, 2, 5, 6: return 2;
            3:             return 32;
            4:             return 4;
            default:       return 65536;
        endcase
    endfunction

    task automatic model_finish();
        m_open     = 1'b0;
        m_done_cnt = 1;
        m_err_pend = m_err_acc;
        m_err_acc  = 1'b0;
        m_cool     = 2;
    endtask

    task automatic model_step();
        if (rst) begin
            m_open = 0; m_drop = 0; m_err_acc = 0; m_err_pend = 0;
            m_rem = 0; m_op = 0; m_cool = 0; m_done_cnt = 0;
            e_wr = 0; e_done = 0; e_err = 0; e_busy = 0; e_op = 0; e_rca = 0;
        end else begin
            m_acc  = cfg_valid && (m_cool == 0);
            m_w    = cfg_data;
            e_wr   = 0;
            e_done = 0;
            e_err  = 0;
            if (m_done_cnt > 0) begin
                m_done_cnt--;
                if (m_done_cnt == 0) begin
                    e_done = 1;
                    e_err  = m_err_pend;
                    e_busy = 0;
                end
            end
            if (m_cool > 0) m_cool--;
            if (m_acc) begin
                if (!m_open) begin
                    m_op   = int'(m_w[31:28]);
                    e_rca  = int'(m_w[27:24]) % 4;
                    e_busy = 1;
                    m_rem  = int'(m_w[15:0]);
                    if (m_rem == 0) begin
                        m_err_acc = 0;
                        model_finish();
                    end else begin
                        m_open    = 1;
                        m_drop    = (m_op >= 8) || (int'(m_w[27:24]) >= 4);
                        m_err_acc = m_drop;
                    end
                end else begin
                    m_rem--;
                    if (!m_drop) begin
                        if (int'(m_w[31:16]) < idx_limit(m_op)) begin
                            e_wr  = 1;
                            e_op  = m_op;
                            e_idx = int'(m_w[31:16]);
                            e_val = int'(m_w[15:0]);
                        end else begin
                            m_err_acc = 1;
                        end
                    end
                    if (m_rem == 0) model_finish();
                end
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // ---------------- observed-write log for literal checks ----------------
    typedef struct {
        int kind;
        int a;
        int d;
        int sd;
    } wr_t;
    wr_t wlog[$];
    int  n_done = 0;
    int  n_done_err = 0;

    initial forever begin
        @(negedge clk);
        if (!rst) begin
            chk("cfg_ready", cfg_ready, m_cool == 0);
            chk("busy", busy, e_busy);
            chk("done", done, e_done);
            chk("rca_sel_issue", rca_sel_issue, e_rca);
            if (e_done) chk("err", err, e_err);
            chk("cpu_fb_wr_en", cpu_fb_reg_addr_wr_en, e_wr && (e_op == 0 || e_op == 1));
            chk("cpu_nfb_wr_en", cpu_nfb_reg_addr_wr_en, e_wr && e_op == 2);
            chk("grid_wr_en", grid_mux_wr_en, e_wr && e_op == 3);
            chk("io_wr_en", io_mux_wr_en, e_wr && e_op == 4);
            chk("res_fb_wr_en", rca_fb_result_mux_wr_en, e_wr && e_op == 5);
            chk("res_nfb_wr_en", rca_nfb_result_mux_wr_en, e_wr && e_op == 6);
            chk("map_wr_en", rca_io_inp_map_wr_en, e_wr && e_op == 7);
            if (e_wr) begin
                case (e_op)
                    0, 1, 2: begin
                        chk("cpu_port_sel", cpu_port_sel, e_idx % 2);
                        chk("cpu_src_dest", cpu_src_dest_port, e_op != 0);
                        chk("cpu_reg_addr", cpu_reg_addr, e_val % 32);
                    end
                    3: begin
                        chk("grid_addr", grid_mux_wr_addr, e_idx);
                        chk("grid_sel", new_grid_mux_sel, e_val % 8);
                    end
                    4: begin
                        chk("io_addr", io_mux_addr, e_idx);
                        chk("io_sel", new_io_mux_sel, e_val % 8);
                    end
                    5, 6: begin
                        chk("res_addr", rca_result_mux_addr, e_idx);
                        chk("res_sel", new_rca_result_mux_sel, e_val % 4);
                    end
                    default: chk("map_val", new_rca_io_inp_map, e_val % 16);
                endcase
            end
            if (cpu_fb_reg_addr_wr_en)
                wlog.push_back('{1, int'(cpu_port_sel), int'(cpu_reg_addr), int'(cpu_src_dest_port)});
            else if (cpu_nfb_reg_addr_wr_en)
                wlog.push_back('{2, int'(cpu_port_sel), int'(cpu_reg_addr), int'(cpu_src_dest_port)});
            else if (grid_mux_wr_en)
                wlog.push_back('{3, int'(grid_mux_wr_addr), int'(new_grid_mux_sel), 0});
            else if (io_mux_wr_en)
                wlog.push_back('{4, int'(io_mux_addr), int'(new_io_mux_sel), 0});
            else if (rca_fb_result_mux_wr_en)
                wlog.push_back('{5, int'(rca_result_mux_addr), int'(new_rca_result_mux_sel), 0});
            else if (rca_nfb_result_mux_wr_en)
                wlog.push_back('{6, int'(rca_result_mux_addr), int'(new_rca_result_mux_sel), 0});
            else if (rca_io_inp_map_wr_en)
                wlog.push_back('{7, 0, int'(new_rca_io_inp_map), 0});
            if (done) begin
                n_done++;
                if (err) n_done_err++;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [31:0] hdr(input int op, input int id, input int n);
        logic [31:0] w;
        w = {op[3:0], id[3:0], 8'h00, n[15:0]};
        return w;
    endfunction

    function automatic logic [31:0] pw(input int idx, input int val);
        logic [31:0] w;
        w = {idx[15:0], val[15:0]};
        return w;
    endfunction

    task automatic send_word(input logic [31:0] w);
        int gap;
        bit got;
        gap = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
        repeat (gap) @(negedge clk);
        cfg_data  = w;
        cfg_valid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            got = cfg_ready;
            @(negedge clk);
        end
        cfg_valid = 1'b0;
        chk("word_accepted", got, 1'b1);
    endtask

    task automatic clear_log();
        wlog.delete();
        n_done = 0;
        n_done_err = 0;
    endtask

    task automatic chk_wr(input string name, input int i, input int kind, input int a,
                          input int d);
        if (wlog.size() > i) begin
            chk({name, "_kind"}, wlog[i].kind, kind);
            chk({name, "_addr"}, wlog[i].a, a);
            chk({name, "_data"}, wlog[i].d, d);
        end else begin
            chk({name, "_present"}, wlog.size(), i + 1);
        end
    endtask

    initial begin
        int op, id, n, idx;
        cfg_valid = 1'b0;
        cfg_data  = '0;
        rst       = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {cfg_ready, rca_sel_issue, busy, done, err, grid_mux_wr_en,
            cpu_fb_reg_addr_wr_en, io_mux_wr_en, rca_io_inp_map_wr_en}, 0);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("post_reset_ready", cfg_ready, 1);
        chk("post_reset_busy", busy, 0);

        // grid mux packet
        clear_log();
        send_word(hdr(3, 1, 2));
        send_word(pw(5, 6));
        send_word(pw(31, 7));
        repeat (4) @(negedge clk);
        chk("t1_nwr", wlog.size(), 2);
        chk_wr("t1_w0", 0, 3, 5, 6);
        chk_wr("t1_w1", 1, 3, 31, 7);
        chk("t1_rca", rca_sel_issue, 1);
        chk("t1_done", n_done, 1);
        chk("t1_err", n_done_err, 0);

        // CPU src fb, then dest nfb
        clear_log();
        send_word(hdr(0, 2, 1));
        send_word(pw(1, 17));
        send_word(hdr(2, 2, 1));
        send_word(pw(0, 9));
        repeat (4) @(negedge clk);
        chk_wr("t2_w0", 0, 1, 1, 17);
        chk_wr("t2_w1", 1, 2, 0, 9);
        if (wlog.size() > 1) begin
            chk("t2_sd0", wlog[0].sd, 0);
            chk("t2_sd1", wlog[1].sd, 1);
        end
        chk("t2_done", n_done, 2);

        // illegal opcode drains its payload
        clear_log();
        send_word(hdr(9, 0, 3));
        send_word(pw(0, 1));
        send_word(pw(1, 2));
        send_word(pw(2, 3));
        repeat (4) @(negedge clk);
        chk("t3_nwr", wlog.size(), 0);
        chk("t3_done_err", n_done_err, 1);

        // IO mux with an out-of-range row, then an empty packet
        clear_log();
        send_word(hdr(4, 3, 2));
        send_word(pw(7, 1));
        send_word(pw(2, 3));
        repeat (4) @(negedge clk);
        chk("t4_nwr", wlog.size(), 1);
        chk_wr("t4_w0", 0, 4, 2, 3);
        chk("t4_done_err", n_done_err, 1);
        clear_log();
        send_word(hdr(3, 0, 0));
        repeat (4) @(negedge clk);
        chk("t4_empty_nwr", wlog.size(), 0);
        chk("t4_empty_done", n_done, 1);
        chk("t4_empty_err", n_done_err, 0);

        // result mux fb with valid gaps
        clear_log();
        max_gap = 3;
        send_word(hdr(5, 1, 4));
        send_word(pw(0, 1));
        send_word(pw(1, 2));
        send_word(pw(0, 3));
        send_word(pw(1, 0));
        repeat (4) @(negedge clk);
        chk("t5_nwr", wlog.size(), 4);
        chk_wr("t5_w0", 0, 5, 0, 1);
        chk_wr("t5_w1", 1, 5, 1, 2);
        chk_wr("t5_w2", 2, 5, 0, 3);
        chk_wr("t5_w3", 3, 5, 1, 0);

        // random packets
        max_gap = 2;
        for (int p = 0; p < 60; p++) begin
            op = ($urandom_range(0, 4) == 0) ? $urandom_range(8, 15) : $urandom_range(0, 7);
            id = $urandom_range(0, 4);
            n  = $urandom_range(0, 5);
            send_word(hdr(op, id, n));
            for (int k = 0; k < n; k++) begin
                idx = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 40) : $urandom_range(0, 3);
                send_word(pw(idx, int'($urandom_range(0, 65535))));
            end
        end
        max_gap = 0;
        repeat (4) @(negedge clk);

        // reset in the middle of a packet
        send_word(hdr(6, 0, 4));
        send_word(pw(0, 1));
        send_word(pw(1, 2));
        @(negedge clk);
        #2 rst = 1'b1;
        #1 chk("midrst_outputs", {cfg_ready, rca_sel_issue, busy, done, err,
            cpu_fb_reg_addr_wr_en, cpu_nfb_reg_addr_wr_en, cpu_port_sel, cpu_src_dest_port,
            cpu_reg_addr, grid_mux_wr_en, io_mux_wr_en, rca_fb_result_mux_wr_en,
            rca_nfb_result_mux_wr_en, rca_result_mux_addr, new_rca_result_mux_sel,
            rca_io_inp_map_wr_en}, 0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        clear_log();
        @(negedge clk);
        send_word(pw(0, 0));
        send_word(pw(1, 0));
        repeat (5) @(negedge clk);
        chk("postrst_nwr", wlog.size(), 0);
        chk("postrst_done", n_done, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
